// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the R-type execution sequencer: opcodes, ALU function codes,
// sequencer states and the R-type legality check.
package riscv_pkg;

    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] FUNCT7_ALT = 7'b0100000;

    // Encoded as {instr[30], instr[25], instr[14:12]}
    typedef enum logic [4:0] {
        FnAdd  = 5'b00000,
        FnSll  = 5'b00001,
        FnSlt  = 5'b00010,
        FnSltu = 5'b00011,
        FnXor  = 5'b00100,
        FnSrl  = 5'b00101,
        FnOr   = 5'b00110,
        FnAnd  = 5'b00111,
        FnSub  = 5'b10000,
        FnSra  = 5'b10101
    } r_func_e;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StRd1  = 3'd1,
        StRd2  = 3'd2,
        StExec = 3'd3,
        StWb   = 3'd4,
        StIll  = 3'd5
    } seq_state_e;

    function automatic logic rtype_legal(input logic [31:0] instr);
        logic [6:0] w_f7;
        logic [2:0] w_f3;
        w_f7 = instr[31:25];
        w_f3 = instr[14:12];
        return (instr[6:0] == OPC_RTYPE) &&
               ((w_f7 == 7'b0) ||
                ((w_f7 == FUNCT7_ALT) && ((w_f3 == 3'b000) || (w_f3 == 3'b101))));
    endfunction

endpackage

// File: rtl/rtype_exec_seq_decode.sv
// Combinational R-type field extraction and legality check.
module rtype_decode
    import riscv_pkg::*;
(
    input  logic [31:0] i_instr,
    output logic [4:0]  o_rs1,
    output logic [4:0]  o_rs2,
    output logic [4:0]  o_rd,
    output r_func_e     o_func,
    output logic        o_legal
);

    always_comb begin
        o_rs1   = i_instr[19:15];
        o_rs2   = i_instr[24:20];
        o_rd    = i_instr[11:7];
        o_func  = r_func_e'({i_instr[30], i_instr[25], i_instr[14:12]});
        o_legal = rtype_legal(i_instr);
    end

endmodule

// File: rtl/rtype_exec_seq.sv
// Multi-cycle R-type sequencer sharing one regfile read port between rs1, rs2 and write-back
// to rd; drives the external combinational R-type ALU and counts retirements.
module rtype_exec_seq
    import riscv_pkg::*;
#(
    parameter int unsigned RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                instr_valid,
    input  logic [31:0]         instr,
    output logic                instr_ready,
    input  logic                flush,
    output logic [4:0]          rf_raddr,
    input  logic [31:0]         rf_rdata,
    output logic                rf_we,
    output logic [4:0]          rf_waddr,
    output logic [31:0]         rf_wdata,
    output logic [4:0]          alu_func,
    output logic [31:0]         alu_rv1,
    output logic [31:0]         alu_rv2,
    input  logic [31:0]         alu_result,
    output logic                done,
    output logic                illegal,
    output logic [RETIRE_W-1:0] retired_cnt
);

    seq_state_e          r_state, w_state_d;
    logic [31:0]         r_instr, r_op_a, r_op_b, r_res;
    logic [31:0]         r_alu_rv1, r_alu_rv2;
    r_func_e             r_alu_func;
    logic [RETIRE_W-1:0] r_retired_cnt;

    logic [31:0] w_dec_instr, w_op_a_d, w_op_b_d;
    logic [4:0]  w_rs1, w_rs2, w_rd;
    r_func_e     w_func;
    logic        w_legal, w_transfer, w_done;

    // In IDLE the incoming word is judged; afterwards fields come from the latched word.
    assign w_dec_instr = (r_state == StIdle) ? instr : r_instr;

    rtype_decode u_decode (
        .i_instr (w_dec_instr),
        .o_rs1   (w_rs1),
        .o_rs2   (w_rs2),
        .o_rd    (w_rd),
        .o_func  (w_func),
        .o_legal (w_legal)
    );

    assign instr_ready = (r_state == StIdle) && !flush;
    assign w_transfer  = instr_valid && instr_ready;
    assign w_done      = (r_state == StWb) && !flush && !reset;

    assign done        = w_done;
    assign rf_we       = w_done && (w_rd != 5'd0);
    assign illegal     = (r_state == StIll) && !reset;
    assign rf_waddr    = (r_state == StWb) ? w_rd : 5'd0;
    assign rf_wdata    = (r_state == StWb) ? r_res : 32'd0;
    assign alu_func    = r_alu_func;
    assign alu_rv1     = r_alu_rv1;
    assign alu_rv2     = r_alu_rv2;
    assign retired_cnt = r_retired_cnt;

    always_comb begin
        w_state_d = r_state;
        w_op_a_d  = r_op_a;
        w_op_b_d  = r_op_b;
        rf_raddr  = 5'd0;
        case (r_state)
            StIdle: if (w_transfer) w_state_d = w_legal ? StRd1 : StIll;
            StRd1: begin
                rf_raddr = w_rs1;
                w_op_a_d = rf_rdata;
                if (w_rs1 == w_rs2) begin
                    w_op_b_d  = rf_rdata;
                    w_state_d = StExec;
                end else begin
                    w_state_d = StRd2;
                end
            end
            StRd2: begin
                rf_raddr  = w_rs2;
                w_op_b_d  = rf_rdata;
                w_state_d = StExec;
            end
            StExec:  w_state_d = StWb;
            StWb:    w_state_d = StIdle;
            StIll:   w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
        if (flush) w_state_d = StIdle;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= StIdle;
            r_instr       <= 32'd0;
            r_op_a        <= 32'd0;
            r_op_b        <= 32'd0;
            r_res         <= 32'd0;
            r_alu_rv1     <= 32'd0;
            r_alu_rv2     <= 32'd0;
            r_alu_func    <= FnAdd;
            r_retired_cnt <= '0;
        end else begin
            r_state <= w_state_d;
            r_op_a  <= w_op_a_d;
            r_op_b  <= w_op_b_d;
            if (w_transfer) r_instr <= instr;
            if (r_state == StExec) r_res <= alu_result;
            // ALU operands only change on entry to EXEC so they hold between instructions.
            if (w_state_d == StExec) begin
                r_alu_rv1  <= w_op_a_d;
                r_alu_rv2  <= w_op_b_d;
                r_alu_func <= w_func;
            end
            if (w_done) r_retired_cnt <= r_retired_cnt + 1'b1;
        end
    end

endmodule
